// File: rtl/adc_interface_pkg.sv
// Shared types and default timing for the LTC25xx-style SAR ADC capture interface.
package adc_interface_pkg;

    typedef enum logic [0:0] {
        CONFIG = 1'b0,
        RUN    = 1'b1
    } adc_state_e;

    localparam int CFG_BITS  = 12;
    localparam int WORD_BITS = 32;
    localparam int CNT_W     = 16;
    localparam int BIT_IDX_W = 6;

    localparam logic [CFG_BITS-1:0] DEF_ADC_CONFIG   = 12'h000;
    localparam int                  DEF_FRAME_CYCLES = 96;
    localparam int                  DEF_MCLK_HIGH    = 2;
    localparam int                  DEF_READ_START   = 16;

    // MSB-first selection of a configuration bit by its serial position.
    function automatic logic cfg_bit(input logic [CFG_BITS-1:0] cfg,
                                     input logic [BIT_IDX_W-1:0] idx);
        logic bit_s;
        if (idx < BIT_IDX_W'(CFG_BITS)) begin
            bit_s = cfg[4'(CFG_BITS - 1) - idx[3:0]];
        end else begin
            bit_s = 1'b0;
        end
        return bit_s;
    endfunction

endpackage

// File: rtl/adc_serial_shifter.sv
// SCKA generator and bit counter shared by the config shift-out and the data shift-in windows.
module adc_serial_shifter
    import adc_interface_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 en_i,
    input  logic [BIT_IDX_W-1:0] last_bit_i,
    output logic                 scka_o,
    output logic [BIT_IDX_W-1:0] bit_idx_o,
    output logic                 sample_o,
    output logic                 last_o
);

    logic [BIT_IDX_W:0] step_q;
    logic [BIT_IDX_W:0] step_d;
    logic               scka_q;
    logic               scka_d;

    // Each bit is a low step then a high step; leaving the window rewinds to step 0.
    always_comb begin
        step_d = {(BIT_IDX_W + 1){1'b0}};
        scka_d = 1'b0;
        if (en_i) begin
            step_d = step_q + {{BIT_IDX_W{1'b0}}, 1'b1};
            scka_d = step_q[0];
        end else begin
            step_d = {(BIT_IDX_W + 1){1'b0}};
            scka_d = 1'b0;
        end
    end

    // Step counter and registered serial clock.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            step_q <= {(BIT_IDX_W + 1){1'b0}};
            scka_q <= 1'b0;
        end else begin
            step_q <= step_d;
            scka_q <= scka_d;
        end
    end

    assign scka_o    = scka_q;
    assign bit_idx_o = step_q[BIT_IDX_W:1];
    // The edge that lifts scka_q is the edge on which the data bit is taken.
    assign sample_o  = en_i & step_q[0];
    assign last_o    = sample_o & (bit_idx_o == last_bit_i);

endmodule

// File: rtl/adc_interface.sv
// ADC config/conversion/readout sequencer with Xillybus read_32 FIFO push.
// Define ADC_TEST_PATTERN_EN to replace ADC data with a per-word counter.
module adc_interface
    import adc_interface_pkg::*;
#(
    parameter logic [CFG_BITS-1:0] ADC_CONFIG   = DEF_ADC_CONFIG,
    parameter int                  FRAME_CYCLES = DEF_FRAME_CYCLES,
    parameter int                  MCLK_HIGH    = DEF_MCLK_HIGH,
    parameter int                  READ_START   = DEF_READ_START
)(
    input  logic                 capture_clk,
    input  logic                 capture_rst_n,
    output logic                 adc_mclk,
    output logic                 adc_scka,
    output logic                 adc_sync,
    output logic                 adc_sdi,
    input  logic                 adc1_sdoa,
    output logic [WORD_BITS-1:0] capture_data,
    output logic                 capture_en,
    input  logic                 capture_full,
    input  logic                 user_r_read_32_open
);

    localparam logic [CNT_W-1:0]     CNT_ZERO      = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]     CNT_ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0]     CFG_LAST      = CNT_W'(2 * CFG_BITS);
    localparam logic [CNT_W-1:0]     FRAME_LAST    = CNT_W'(FRAME_CYCLES - 1);
    localparam logic [CNT_W-1:0]     MCLK_END      = CNT_W'(MCLK_HIGH);
    localparam logic [CNT_W-1:0]     RD_FIRST      = CNT_W'(READ_START);
    localparam logic [CNT_W-1:0]     RD_LAST       = CNT_W'(READ_START + 2 * WORD_BITS - 1);
    localparam logic [BIT_IDX_W-1:0] CFG_LAST_BIT  = BIT_IDX_W'(CFG_BITS - 1);
    localparam logic [BIT_IDX_W-1:0] WORD_LAST_BIT = BIT_IDX_W'(WORD_BITS - 1);

    adc_state_e           state_q;
    adc_state_e           state_d;
    logic [CNT_W-1:0]     cnt_q;
    logic [CNT_W-1:0]     cnt_d;

    logic                 mclk_q;
    logic                 mclk_d;
    logic                 sync_q;
    logic                 sync_d;
    logic                 sdi_q;
    logic                 sdi_d;
    logic                 shift_en_s;
    logic [BIT_IDX_W-1:0] last_bit_s;

    logic                 scka_s;
    logic [BIT_IDX_W-1:0] bit_idx_s;
    logic                 sample_s;
    logic                 last_s;

    logic [WORD_BITS-1:0] shift_q;
    logic [WORD_BITS-1:0] shift_d;
    logic                 word_done_q;
    logic                 word_done_d;
    logic                 cap_en_q;
    logic                 cap_en_d;
    logic [WORD_BITS-1:0] cap_data_q;
    logic [WORD_BITS-1:0] cap_data_d;
    logic [WORD_BITS-1:0] word_src_s;

    adc_serial_shifter u_shifter (
        .clk_i      (capture_clk),
        .rst_n_i    (capture_rst_n),
        .en_i       (shift_en_s),
        .last_bit_i (last_bit_s),
        .scka_o     (scka_s),
        .bit_idx_o  (bit_idx_s),
        .sample_o   (sample_s),
        .last_o     (last_s)
    );

    // State and frame/config cycle counter.
    always_ff @(posedge capture_clk or negedge capture_rst_n) begin
        if (!capture_rst_n) begin
            state_q <= CONFIG;
            cnt_q   <= CNT_ZERO;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // CONFIG runs once (sync plus 12 two-cycle bits), then RUN frames repeat forever.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_ONE;
        case (state_q)
            CONFIG: begin
                if (cnt_q == CFG_LAST) begin
                    state_d = RUN;
                    cnt_d   = CNT_ZERO;
                end else begin
                    state_d = CONFIG;
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            RUN: begin
                if (cnt_q == FRAME_LAST) begin
                    cnt_d = CNT_ZERO;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = CONFIG;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // Pin levels and shift window for the cycle after the current counter value.
    always_comb begin
        mclk_d     = 1'b0;
        sync_d     = 1'b0;
        sdi_d      = 1'b0;
        shift_en_s = 1'b0;
        last_bit_s = WORD_LAST_BIT;
        case (state_q)
            CONFIG: begin
                sync_d     = (cnt_q == CNT_ZERO);
                shift_en_s = (cnt_q != CNT_ZERO) && (cnt_q <= CFG_LAST);
                last_bit_s = CFG_LAST_BIT;
                if (shift_en_s) begin
                    sdi_d = cfg_bit(ADC_CONFIG, bit_idx_s);
                end else begin
                    sdi_d = 1'b0;
                end
            end
            RUN: begin
                mclk_d     = (cnt_q < MCLK_END);
                sync_d     = (cnt_q == CNT_ONE);
                shift_en_s = (cnt_q >= RD_FIRST) && (cnt_q <= RD_LAST);
                last_bit_s = WORD_LAST_BIT;
            end
            default: begin
                mclk_d     = 1'b0;
                sync_d     = 1'b0;
                sdi_d      = 1'b0;
                shift_en_s = 1'b0;
            end
        endcase
    end

`ifdef ADC_TEST_PATTERN_EN
    logic [WORD_BITS-1:0] pat_q;
    logic [WORD_BITS-1:0] pat_d;
    logic                 unused_shift_s;

    // Pattern counter advances on every completed word, written or dropped.
    always_comb begin
        if (word_done_q) begin
            pat_d = pat_q + {{(WORD_BITS - 1){1'b0}}, 1'b1};
        end else begin
            pat_d = pat_q;
        end
    end

    // Test pattern counter register.
    always_ff @(posedge capture_clk or negedge capture_rst_n) begin
        if (!capture_rst_n) begin
            pat_q <= {WORD_BITS{1'b0}};
        end else begin
            pat_q <= pat_d;
        end
    end

    assign word_src_s     = pat_q;
    assign unused_shift_s = ^shift_q;
`else
    assign word_src_s = shift_q;
`endif

    // Readout shift register, word completion and FIFO handshake.
    always_comb begin
        shift_d     = shift_q;
        word_done_d = 1'b0;
        cap_en_d    = 1'b0;
        cap_data_d  = cap_data_q;
        if ((state_q == RUN) && sample_s) begin
            shift_d = {shift_q[WORD_BITS-2:0], adc1_sdoa};
        end else begin
            shift_d = shift_q;
        end
        if ((state_q == RUN) && last_s) begin
            word_done_d = 1'b1;
        end else begin
            word_done_d = 1'b0;
        end
        // Gating is looked at only here, so a word is either written whole or dropped.
        if (word_done_q && user_r_read_32_open && !capture_full) begin
            cap_en_d   = 1'b1;
            cap_data_d = word_src_s;
        end else begin
            cap_en_d   = 1'b0;
            cap_data_d = cap_data_q;
        end
    end

    // Output and datapath registers.
    always_ff @(posedge capture_clk or negedge capture_rst_n) begin
        if (!capture_rst_n) begin
            mclk_q      <= 1'b0;
            sync_q      <= 1'b0;
            sdi_q       <= 1'b0;
            shift_q     <= {WORD_BITS{1'b0}};
            word_done_q <= 1'b0;
            cap_en_q    <= 1'b0;
            cap_data_q  <= {WORD_BITS{1'b0}};
        end else begin
            mclk_q      <= mclk_d;
            sync_q      <= sync_d;
            sdi_q       <= sdi_d;
            shift_q     <= shift_d;
            word_done_q <= word_done_d;
            cap_en_q    <= cap_en_d;
            cap_data_q  <= cap_data_d;
        end
    end

    assign adc_mclk     = mclk_q;
    assign adc_scka     = scka_s;
    assign adc_sync     = sync_q;
    assign adc_sdi      = sdi_q;
    assign capture_en   = cap_en_q;
    assign capture_data = cap_data_q;

endmodule

// File: tb/tb_adc_interface.sv
// Bench for adc_interface: pin-level ADC model, expected-word queue and FIFO-port monitor.
// Follows ADC_TEST_PATTERN_EN the same way the design does.
module tb_adc_interface;

    localparam logic [11:0] CFG   = 12'hA5C;
    localparam int          FRAME = 96;
`ifdef ADC_TEST_PATTERN_EN
    localparam int          FULL_FRAMES = 2;
`else
    localparam int          FULL_FRAMES = 3;
`endif

    logic        capture_clk = 1'b0;
    logic        capture_rst_n = 1'b0;
    logic        adc_mclk;
    logic        adc_scka;
    logic        adc_sync;
    logic        adc_sdi;
    logic        adc1_sdoa;
    logic [31:0] capture_data;
    logic        capture_en;
    logic        capture_full = 1'b0;
    logic        user_r_read_32_open = 1'b0;

    int checks = 0;
    int errors = 0;

    adc_interface #(
        .ADC_CONFIG   (CFG),
        .FRAME_CYCLES (FRAME),
        .MCLK_HIGH    (2),
        .READ_START   (16)
    ) dut (
        .capture_clk         (capture_clk),
        .capture_rst_n       (capture_rst_n),
        .adc_mclk            (adc_mclk),
        .adc_scka            (adc_scka),
        .adc_sync            (adc_sync),
        .adc_sdi             (adc_sdi),
        .adc1_sdoa           (adc1_sdoa),
        .capture_data        (capture_data),
        .capture_en          (capture_en),
        .capture_full        (capture_full),
        .user_r_read_32_open (user_r_read_32_open)
    );

    always #5 capture_clk = ~capture_clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // ADC model and reference of which words must reach the FIFO
    logic [31:0] adc_reg = 32'h0;
    logic [3:0]  adc_n = 4'h0;
    logic [31:0] loaded = 32'h0;
    logic [31:0] word_val = 32'h0;
    logic [31:0] pat_cnt = 32'h0;
    logic [11:0] cfg_word = 12'h0;
    logic [31:0] exp_q[$];
    int          rise_cnt = 0;
    int          cfg_rises = 0;
    int          cfg_syncs = 0;
    int          cfg_done = 0;
    bit          pend = 1'b0;
    bit          cfg_active = 1'b1;
    bit          prev_sync = 1'b0;
    bit          prev_scka = 1'b0;
    bit          prev_mclk = 1'b0;

    assign adc1_sdoa = adc_reg[31];

    always @(posedge capture_clk) begin
        #1;
        if (!capture_rst_n) begin
            exp_q.delete();
            rise_cnt   = 0;
            pend       = 1'b0;
            pat_cnt    = 32'h0;
            cfg_active = 1'b1;
            cfg_rises  = 0;
            cfg_syncs  = 0;
            cfg_word   = 12'h0;
        end else begin
            if (pend) begin
                pend = 1'b0;
                if (user_r_read_32_open && !capture_full) exp_q.push_back(word_val);
            end
            if (adc_sync && !prev_sync) begin
                adc_reg  = {adc_n, 4'hA, adc_n, 4'hB, adc_n, 4'hC, adc_n, 4'hD};
                loaded   = adc_reg;
                adc_n    = adc_n + 4'h1;
                rise_cnt = 0;
                if (cfg_active) cfg_syncs++;
            end
            if (adc_scka && !prev_scka) begin
                if (cfg_active) begin
                    cfg_word = {cfg_word[10:0], adc_sdi};
                    cfg_rises++;
                end else begin
                    chk("run_sdi_low", {31'h0, adc_sdi}, 32'h0);
                end
                adc_reg = adc_reg << 1;
                rise_cnt++;
                if (rise_cnt == 32) begin
                    pend = 1'b1;
`ifdef ADC_TEST_PATTERN_EN
                    word_val = pat_cnt;
`else
                    word_val = loaded;
`endif
                    pat_cnt = pat_cnt + 32'h1;
                end
            end
            if (adc_mclk && !prev_mclk && cfg_active) begin
                chk("cfg_scka_pulses", 32'(cfg_rises), 32'd12);
                chk("cfg_sdi_word", {20'h0, cfg_word}, {20'h0, CFG});
                chk("cfg_sync_count", 32'(cfg_syncs), 32'd1);
                cfg_active = 1'b0;
                cfg_done++;
            end
        end
        prev_sync = adc_sync;
        prev_scka = adc_scka;
        prev_mclk = adc_mclk;
    end

    // FIFO-port monitor: every write must match the oldest expected word
    logic [31:0] last_exp = 32'h0;
    logic [31:0] exp_v;
    int          wr_count = 0;

    always @(posedge capture_clk) begin
        #2;
        if (!capture_rst_n) begin
            last_exp = 32'h0;
        end else if (capture_en) begin
            wr_count++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got data %h with no word due", capture_data);
            end else begin
                exp_v = exp_q.pop_front();
                chk("write_data", capture_data, exp_v);
                last_exp = exp_v;
            end
        end else begin
            if (exp_q.size() != 0) begin
                exp_v = exp_q.pop_front();
                checks++;
                errors++;
                $display("FAIL missing_write: capture_en 0, want write of %h", exp_v);
            end
            chk("data_hold", capture_data, last_exp);
        end
    end

    task automatic wait_write(input int budget, input string what);
        int  start;
        bit  seen;
        start = wr_count;
        seen  = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge capture_clk);
            if (wr_count != start) seen = 1'b1;
        end
        chk(what, {31'h0, seen}, 32'h1);
    endtask

    task automatic wait_rise(input int target, input int budget, input string what);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge capture_clk);
            if (rise_cnt == target && !cfg_active) seen = 1'b1;
        end
        chk(what, {31'h0, seen}, 32'h1);
    endtask

    logic [31:0] prev_word;
    logic [31:0] got_word;
    int          w0;

    initial begin
        repeat (3) @(negedge capture_clk);
        chk("reset_en", {31'h0, capture_en}, 32'h0);
        chk("reset_data", capture_data, 32'h0);
        chk("reset_mclk", {31'h0, adc_mclk}, 32'h0);
        capture_rst_n = 1'b1;

        // Closed channel: config runs, nothing is written
        repeat (97) @(negedge capture_clk);
        chk("closed_no_writes", 32'(wr_count), 32'd0);
        chk("config_completed", 32'(cfg_done), 32'd1);

        // Open channel: one write per frame
        user_r_read_32_open = 1'b1;
        w0 = wr_count;
        repeat (2000) @(negedge capture_clk);
        checks++;
        if ((wr_count - w0) < 20 || (wr_count - w0) > 21) begin
            errors++;
            $display("FAIL write_rate: got %0d writes in 2000 cycles want 20..21", wr_count - w0);
        end

        // FIFO full over several completions: those words are skipped
        wait_write(300, "pre_full_write");
        prev_word = last_exp;
        capture_full = 1'b1;
        w0 = wr_count;
        repeat (FULL_FRAMES * FRAME) @(negedge capture_clk);
        chk("full_no_writes", 32'(wr_count - w0), 32'd0);
        capture_full = 1'b0;
        wait_write(300, "resume_after_full");
        got_word = capture_data;
`ifdef ADC_TEST_PATTERN_EN
        chk("full_skip", got_word, prev_word + 32'(FULL_FRAMES + 1));
`else
        chk("full_skip_n", {28'h0, got_word[31:28]}, {28'h0, prev_word[31:28] + 4'(FULL_FRAMES + 1)});
`endif

        // Close mid-readout, reopen later
        wait_rise(10, 300, "reach_mid_readout");
        user_r_read_32_open = 1'b0;
        w0 = wr_count;
        repeat (100) @(negedge capture_clk);
        chk("closed_mid_frame", 32'(wr_count - w0), 32'd0);
        user_r_read_32_open = 1'b1;
        wait_write(200, "reopen_write");

        // Random open/full traffic, reference model judges every word
        for (int i = 0; i < 2500; i++) begin
            @(negedge capture_clk);
            if ($urandom_range(0, 49) == 0) user_r_read_32_open = ~user_r_read_32_open;
            if ($urandom_range(0, 63) == 0) capture_full = ~capture_full;
        end
        user_r_read_32_open = 1'b1;
        capture_full = 1'b0;

        // Asynchronous reset in the middle of a readout
        wait_rise(16, 300, "reach_reset_point");
        #2;
        capture_rst_n = 1'b0;
        #1;
        chk("async_rst_en", {31'h0, capture_en}, 32'h0);
        chk("async_rst_data", capture_data, 32'h0);
        chk("async_rst_scka", {31'h0, adc_scka}, 32'h0);
        chk("async_rst_mclk", {31'h0, adc_mclk}, 32'h0);
        chk("async_rst_sync", {31'h0, adc_sync}, 32'h0);
        chk("async_rst_sdi", {31'h0, adc_sdi}, 32'h0);
        repeat (3) @(negedge capture_clk);
        capture_rst_n = 1'b1;
        repeat (150) @(negedge capture_clk);
        chk("config_redone", 32'(cfg_done), 32'd2);
        wait_write(200, "post_reset_write");

        repeat (20) @(negedge capture_clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
